apb_multi_master: RTL and testbench
===================================

Name: apb_multi_master

Overview:
- Parametrised successor to the single-slave APB master/top.
- A single APB master FSM drives a shared bus to NUM_SLAVES slaves through address decoding, with per-slave PSEL and a read-data/ready/error return mux.
- Adds behaviour the existing block lacks: wait states via PREADY, PSLVERR propagation, decode error for unmapped addresses, a wait-state timeout, and back-to-back transfers.
- Sits between the user request port and the peripheral slaves, in place of the master + slave pair.

Parameters:
ADDR_W, 8, address width (paddr, request addresses).
DATA_W, 8, data width (pwdata, prdata, request data).
NUM_SLAVES, 4, number of slave channels; legal range 1..2**SEL_W.
SEL_W, 2, number of address MSBs used as slave index.
TIMEOUT, 16, maximum ACCESS cycles before forced error completion; must be ≥ 1.

Ports:
PCLK  input  1  clock; all logic on rising edge.
PRESET  input  1  synchronous reset, active-high.
transfer  input  1  request valid; sampled only in IDLE.
READ_WRITE  input  1  1 = write, 0 = read.
apb_write_paddr  input  ADDR_W  write address.
apb_write_data  input  DATA_W  write data.
apb_read_paddr  input  ADDR_W  read address.
apb_read_data_out  output  DATA_W  captured read data.
done  output  1  one-cycle pulse at transfer completion.
error  output  1  valid with done; 1 = PSLVERR, decode error or timeout.
paddr  output  ADDR_W  APB address.
pwdata  output  DATA_W  APB write data.
PWRITE  output  1  APB direction.
PENABLE  output  1  APB enable.
PSEL  output  NUM_SLAVES  one-hot slave select.
PRDATA  input  NUM_SLAVES*DATA_W  flattened slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
PREADY  input  NUM_SLAVES  per-slave ready.
PSLVERR  input  NUM_SLAVES  per-slave error.

Behaviour:
- Reset: synchronous, active-high. While PRESET=1 at a PCLK edge, all outputs go to 0 (paddr, pwdata, PWRITE, PENABLE, PSEL, apb_read_data_out, done, error); FSM to IDLE; timeout counter to 0. Reset mid-transfer abandons the transfer with no done pulse.
- FSM states: IDLE, SETUP, ACCESS, DECERR.
- IDLE:
  - On transfer=1, latch the direction. Latch paddr from apb_write_paddr (write) or apb_read_paddr (read), and pwdata from apb_write_data on writes.
  - Index idx = address[ADDR_W-1 -: SEL_W]. If idx < NUM_SLAVES, go to SETUP with PSEL[idx]=1. Otherwise go to DECERR with PSEL all 0.
- SETUP: PENABLE=0, selected PSEL=1, paddr/pwdata/PWRITE stable. Always go to ACCESS after exactly one cycle.
- ACCESS:
  - PENABLE=1; address, data, direction and PSEL held stable.
  - Each cycle, check PREADY[idx]:
    - 0: increment the timeout counter.
    - 1: completion. Register done=1 and error=PSLVERR[idx]. On a read with PSLVERR=0, capture PRDATA slice idx into apb_read_data_out. On a write or on error, apb_read_data_out holds its previous value.
  - Timeout: if the counter reaches TIMEOUT-1 while PREADY is still 0, the next cycle completes with done=1, error=1 and no data capture.
  - On completion: PSEL and PENABLE go to 0, the counter clears, and the FSM goes to IDLE (or back-to-back, below).
- DECERR: one cycle, no bus activity; done=1, error=1; return to IDLE.
- Back-to-back: if transfer=1 in the completion cycle, go directly to SETUP (or DECERR) with the new request latched. PENABLE drops for the SETUP cycle; there is no IDLE bubble.
- done and error are single-cycle pulses, registered, asserted the cycle after the completion edge; error is 0 whenever done is 0.
- Request inputs are ignored outside IDLE and the completion cycle.
- Only PREADY/PSLVERR/PRDATA of the selected slave are observed; other slaves' inputs have no effect.
- Latency, zero-wait slave: transfer sampled at edge N, SETUP in N+1, ACCESS in N+2, done visible in N+3.

Test Plan:
1. Write, zero wait: transfer=1, READ_WRITE=1, apb_write_paddr=8'h45, data 8'hA5, PREADY[1]=1 -> PSEL=4'b0010 for 2 cycles, PENABLE only in the 2nd, pwdata=A5, done=1, error=0 three cycles after the request.
2. Read with 3 wait states: apb_read_paddr=8'hC2, slave 3 holds PREADY=0 for 3 ACCESS cycles then 1 with PRDATA slice=8'h3C -> PENABLE high for 4 cycles, apb_read_data_out=3C, done pulse, error=0.
3. PSLVERR: read from slave 0 with PREADY=1, PSLVERR=1, PRDATA=8'hFF -> done=1, error=1, apb_read_data_out unchanged.
4. Timeout: TIMEOUT=16, selected slave never asserts PREADY -> ACCESS lasts 16 cycles, then done=1, error=1, PSEL=0; next request proceeds normally.
5. Decode error: NUM_SLAVES=3, address 8'hC0 (idx 3) -> PSEL never asserted, done=1, error=1 two cycles after the request.
6. Back-to-back plus reset: write then read held on transfer -> second SETUP immediately after the first completion. Assert PRESET during a later ACCESS -> all outputs 0 the next cycle, no done pulse.

Source files
------------

// File: rtl/apb_multi_master.sv
// APB master driving NUM_SLAVES slaves over a shared bus with address-MSB decoding,
// wait states, slave error propagation, decode errors, a wait-state timeout and back-to-back transfers.
module apb_multi_master #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int NUM_SLAVES = 4,
   parameter int SEL_W      = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic                         PCLK,
   input  logic                         PRESET,
   input  logic                         transfer,
   input  logic                         READ_WRITE,
   input  logic [ADDR_W-1:0]            apb_write_paddr,
   input  logic [DATA_W-1:0]            apb_write_data,
   input  logic [ADDR_W-1:0]            apb_read_paddr,
   output logic [DATA_W-1:0]            apb_read_data_out,
   output logic                         done,
   output logic                         error,
   output logic [ADDR_W-1:0]            paddr,
   output logic [DATA_W-1:0]            pwdata,
   output logic                         PWRITE,
   output logic                         PENABLE,
   output logic [NUM_SLAVES-1:0]        PSEL,
   input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]        PREADY,
   input  logic [NUM_SLAVES-1:0]        PSLVERR
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_DECERR = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       paddr_q, paddr_d;
   logic [DATA_W-1:0]       pwdata_q, pwdata_d;
   logic                    pwrite_q, pwrite_d;
   logic                    penable_q, penable_d;
   logic [NUM_SLAVES-1:0]   psel_q, psel_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic                    rdy_s;
   logic                    slverr_s;
   logic [DATA_W-1:0]       prdata_s;
   logic [ADDR_W-1:0]       req_addr_s;
   logic [SEL_W-1:0]        req_idx_s;
   logic                    req_hit_s;
   logic [NUM_SLAVES-1:0]   req_sel_s;
   logic                    accept_s;

   // Return path: only the currently selected slave is observed (PSEL is one-hot or zero).
   always_comb begin
      rdy_s    = |(PREADY & psel_q);
      slverr_s = |(PSLVERR & psel_q);
      prdata_s = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         prdata_s = prdata_s | (PRDATA[i*DATA_W +: DATA_W] & {DATA_W{psel_q[i]}});
      end
   end

   // Request address decode into a one-hot select; indices beyond NUM_SLAVES are unmapped.
   always_comb begin
      req_addr_s = READ_WRITE ? apb_write_paddr : apb_read_paddr;
      req_idx_s  = req_addr_s[ADDR_W-1 -: SEL_W];
      req_hit_s  = (int'(req_idx_s) < NUM_SLAVES);
      req_sel_s  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         req_sel_s[i] = (int'(req_idx_s) == i);
      end
   end

   // Next-state and next-output computation for the transfer FSM.
   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pwrite_d  = pwrite_q;
      penable_d = penable_q;
      psel_d    = psel_q;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      accept_s  = 1'b0;

      case (state_q)
         S_IDLE: begin
            accept_s = transfer;
         end
         S_SETUP: begin
            state_d   = S_ACCESS;
            penable_d = 1'b1;
         end
         S_ACCESS: begin
            // A timeout completion only happens while the slave is still not ready.
            if (rdy_s || (cnt_q == CNT_LAST)) begin
               done_d    = 1'b1;
               error_d   = rdy_s ? slverr_s : 1'b1;
               psel_d    = '0;
               penable_d = 1'b0;
               cnt_d     = '0;
               state_d   = S_IDLE;
               accept_s  = transfer;
               if (rdy_s && !slverr_s && !pwrite_q) begin
                  rdata_d = prdata_s;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DECERR: begin
            done_d   = 1'b1;
            error_d  = 1'b1;
            state_d  = S_IDLE;
            accept_s = transfer;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // New request: from IDLE or directly out of a completion cycle (no IDLE bubble).
      if (accept_s) begin
         pwrite_d  = READ_WRITE;
         paddr_d   = req_addr_s;
         pwdata_d  = READ_WRITE ? apb_write_data : pwdata_q;
         psel_d    = req_hit_s ? req_sel_s : '0;
         penable_d = 1'b0;
         state_d   = req_hit_s ? S_SETUP : S_DECERR;
      end else begin
         pwrite_d = pwrite_q;
         paddr_d  = paddr_q;
         pwdata_d = pwdata_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= S_IDLE;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pwrite_q  <= 1'b0;
         penable_q <= 1'b0;
         psel_q    <= '0;
         rdata_q   <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pwrite_q  <= pwrite_d;
         penable_q <= penable_d;
         psel_q    <= psel_d;
         rdata_q   <= rdata_d;
         done_q    <= done_d;
         error_q   <= error_d;
         cnt_q     <= cnt_d;
      end
   end

   assign paddr             = paddr_q;
   assign pwdata            = pwdata_q;
   assign PWRITE            = pwrite_q;
   assign PENABLE           = penable_q;
   assign PSEL              = psel_q;
   assign apb_read_data_out = rdata_q;
   assign done              = done_q;
   assign error             = error_q;

endmodule

// File: tb/tb_apb_multi_master.sv
// Scoreboard bench for apb_multi_master with three slaves so that index 3 is an unmapped region.
module tb_apb_multi_master;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int NS = 3;
   localparam int SW = 2;
   localparam int TO = 16;

   logic             PCLK = 1'b0;
   logic             PRESET;
   logic             transfer;
   logic             READ_WRITE;
   logic [AW-1:0]    apb_write_paddr;
   logic [DW-1:0]    apb_write_data;
   logic [AW-1:0]    apb_read_paddr;
   logic [DW-1:0]    apb_read_data_out;
   logic             done;
   logic             error;
   logic [AW-1:0]    paddr;
   logic [DW-1:0]    pwdata;
   logic             PWRITE;
   logic             PENABLE;
   logic [NS-1:0]    PSEL;
   logic [NS*DW-1:0] PRDATA;
   logic [NS-1:0]    PREADY;
   logic [NS-1:0]    PSLVERR;

   always #5 PCLK = ~PCLK;

   apb_multi_master #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .SEL_W(SW), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .READ_WRITE(READ_WRITE),
      .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
      .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
      .done(done), .error(error), .paddr(paddr), .pwdata(pwdata), .PWRITE(PWRITE),
      .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   typedef struct {
      bit         wr;
      logic [7:0] addr;
      logic [7:0] data;
      int         w;       // wait cycles before PREADY; >= TO means never ready
      bit         slverr;
      logic [7:0] rdata;
      bit         chain;   // issued during the previous transfer's completion cycle
   } txn_t;

   typedef struct {
      logic       err;
      logic [7:0] rd;
      int         cyc;
   } exp_t;

   txn_t       txq[$];
   exp_t       expq[$];
   exp_t       mon_e;
   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   bit         mon_en = 1'b0;
   logic [7:0] model_rd = 8'h00;

   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [NS-1:0] onehot(input int idx);
      logic [NS-1:0] r;
      r = '0;
      if (idx < NS) r[idx] = 1'b1;
      return r;
   endfunction

   task automatic noise();
      PREADY  = 3'($urandom);
      PSLVERR = 3'($urandom);
      PRDATA  = 24'($urandom);
   endtask

   // Drive a request and push the outcome predicted from the transfer rules.
   task automatic set_req(input txn_t t);
      exp_t e;
      int   idx;
      idx             = int'(t.addr[7:6]);
      transfer        = 1'b1;
      READ_WRITE      = t.wr;
      apb_write_paddr = t.wr ? t.addr : 8'($urandom);
      apb_read_paddr  = t.wr ? 8'($urandom) : t.addr;
      apb_write_data  = t.data;
      e.err = (idx >= NS) || (t.w >= TO) || t.slverr;
      if (!t.wr && idx < NS && t.w < TO && !t.slverr) model_rd = t.rdata;
      e.rd  = model_rd;
      e.cyc = cyc + ((idx >= NS) ? 2 : 3 + ((t.w < TO) ? t.w : TO - 1));
      expq.push_back(e);
   endtask

   // Act as the addressed slave for every transfer in txq; entered and left at a falling edge.
   task automatic run_list();
      for (int j = 0; j < txq.size(); j++) begin
         txn_t t;
         int   idx;
         bit   nxt;
         t   = txq[j];
         idx = int'(t.addr[7:6]);
         nxt = (j + 1 < txq.size()) && txq[j+1].chain;
         if (!t.chain) begin
            set_req(t);
            @(posedge PCLK);
         end
         @(negedge PCLK);
         transfer = 1'b0;
         noise();
         if (idx >= NS) begin
            chk("decerr_psel", 32'(PSEL), 32'(0));
            chk("decerr_penable", 32'(PENABLE), 32'(0));
            if (nxt) set_req(txq[j+1]);
            @(posedge PCLK);
         end else begin
            chk("setup_psel", 32'(PSEL), 32'(onehot(idx)));
            chk("setup_penable", 32'(PENABLE), 32'(0));
            chk("setup_paddr", 32'(paddr), 32'(t.addr));
            chk("setup_pwrite", 32'(PWRITE), 32'(t.wr));
            if (t.wr) chk("setup_pwdata", 32'(pwdata), 32'(t.data));
            @(posedge PCLK);
            for (int k = 0; k < TO; k++) begin
               bit last;
               @(negedge PCLK);
               chk("access_penable", 32'(PENABLE), 32'(1));
               chk("access_psel", 32'(PSEL), 32'(onehot(idx)));
               noise();
               PREADY[idx]          = (k == t.w);
               PSLVERR[idx]         = t.slverr;
               PRDATA[idx*DW +: DW] = t.rdata;
               last = (k == t.w) || (k == TO - 1);
               if (last && nxt) set_req(txq[j+1]);
               @(posedge PCLK);
               if (last) break;
            end
         end
         if (!nxt) @(negedge PCLK);
      end
      txq.delete();
   endtask

   // Scoreboard monitor: every done pulse must match the oldest outstanding prediction.
   always @(negedge PCLK) begin
      if (mon_en) begin
         if (done === 1'b1) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
               mon_e = expq.pop_front();
               chk("error", 32'(error), 32'(mon_e.err));
               chk("read_data", 32'(apb_read_data_out), 32'(mon_e.rd));
               chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
         end else begin
            chk("error_without_done", 32'(error), 32'(0));
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_outs"}, {apb_read_data_out, paddr, pwdata, 8'(PSEL)}, 32'(0));
      chk({tag, "_ctrl"}, {28'(0), done, error, PWRITE, PENABLE}, 32'(0));
   endtask

   function automatic txn_t mk(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                               input int w, input bit slverr, input logic [7:0] rdata, input bit chain);
      txn_t t;
      t.wr = wr; t.addr = addr; t.data = data; t.w = w;
      t.slverr = slverr; t.rdata = rdata; t.chain = chain;
      return t;
   endfunction

   initial begin
      PRESET = 1'b1; transfer = 1'b0; READ_WRITE = 1'b0;
      apb_write_paddr = 8'h00; apb_write_data = 8'h00; apb_read_paddr = 8'h00;
      PRDATA = '0; PREADY = '0; PSLVERR = '0;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      chk_all_zero("reset");
      PRESET = 1'b0;
      mon_en = 1'b1;

      txq.push_back(mk(1'b1, 8'h45, 8'hA5, 0,  1'b0, 8'h00, 1'b0)); // zero-wait write, slave 1
      txq.push_back(mk(1'b0, 8'h82, 8'h00, 3,  1'b0, 8'h3C, 1'b0)); // read with 3 waits, slave 2
      txq.push_back(mk(1'b0, 8'h05, 8'h00, 0,  1'b1, 8'hFF, 1'b0)); // PSLVERR, data not captured
      txq.push_back(mk(1'b0, 8'h41, 8'h00, 99, 1'b0, 8'h11, 1'b0)); // timeout
      txq.push_back(mk(1'b1, 8'h47, 8'h5A, 1,  1'b0, 8'h00, 1'b0)); // normal after timeout
      txq.push_back(mk(1'b0, 8'hC0, 8'h00, 0,  1'b0, 8'h22, 1'b0)); // decode error
      txq.push_back(mk(1'b1, 8'h10, 8'h77, 0,  1'b0, 8'h00, 1'b0));
      txq.push_back(mk(1'b0, 8'h90, 8'h00, 2,  1'b0, 8'h99, 1'b1)); // back-to-back
      txq.push_back(mk(1'b1, 8'hF3, 8'h33, 0,  1'b0, 8'h00, 1'b1)); // back-to-back into decode error
      txq.push_back(mk(1'b0, 8'h50, 8'h00, 0,  1'b0, 8'h6B, 1'b1)); // back-to-back out of decode error
      run_list();

      // Reset in the middle of ACCESS: transfer abandoned, no done pulse.
      transfer = 1'b1; READ_WRITE = 1'b0; apb_read_paddr = 8'h48;
      @(posedge PCLK);
      @(negedge PCLK);
      transfer = 1'b0; PREADY = '0;
      @(posedge PCLK);
      @(negedge PCLK);
      chk("mid_access_penable", 32'(PENABLE), 32'(1));
      PRESET = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
      chk_all_zero("mid_reset");
      PRESET = 1'b0;
      model_rd = 8'h00;
      repeat (4) @(negedge PCLK);

      for (int i = 0; i < 60; i++) begin
         txn_t t;
         int   r;
         r = int'($urandom_range(7, 0));
         t = mk(1'($urandom), 8'($urandom), 8'($urandom),
                (r == 7) ? int'($urandom_range(19, 16)) : int'($urandom_range(3, 0)),
                ($urandom_range(4, 0) == 0), 8'($urandom), (i > 0) && 1'($urandom));
         txq.push_back(t);
      end
      run_list();

      repeat (4) @(negedge PCLK);
      chk("scoreboard_empty", 32'(expq.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
